div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 123 ++++++++++++
 tb/tb_div_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle divider control: restoring shift-subtract, one quotient bit per cycle,
// signed (DIV) or unsigned (DIVU), result {remainder, quotient} held until start_i drops.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     pr_q, pr_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qsign_q, qsign_d;
  logic                 rsign_q, rsign_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     a_abs, b_abs, quo, rem;
  logic [WIDTH:0]       diff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pr_d     = pr_q;
    dvs_d    = dvs_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    ready_d  = ready_q;
    quo      = '0;
    rem      = '0;

    a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    // pr_q holds the partial remainder pre-shifted by one, so the trial uses the top WIDTH+1 bits directly
    diff  = pr_q[2*WIDTH:WIDTH] - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          pr_d    = {{WIDTH{1'b0}}, a_abs, 1'b0};
          dvs_d   = b_abs;
          qsign_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rsign_d = signed_div_i & opdata1_i[WIDTH-1];
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = S_END;
      end
      S_ON: begin
        if (diff[WIDTH]) pr_d = {pr_q[2*WIDTH-1:0], 1'b0};
        else             pr_d = {diff[WIDTH-1:0], pr_q[WIDTH-1:0], 1'b1};
        cnt_d = cnt_q + 1'b1;
        quo   = pr_d[WIDTH-1:0];
        rem   = pr_d[2*WIDTH:WIDTH+1];
        if (cnt_q == CW'(WIDTH-1)) begin
          result_d = {(rsign_q ? -rem : rem), (qsign_q ? -quo : quo)};
          ready_d  = 1'b1;
          state_d  = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush beats both a held start and a completing step
    if (annul_i && state_q != S_IDLE) begin
      result_d = '0;
      ready_d  = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pr_q     <= '0;
      dvs_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pr_q     <= pr_d;
      dvs_q    <= dvs_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: transaction-level divide model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: truncating division, remainder takes the dividend's sign
  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Transaction model: an accepted request yields its result after a fixed number of edges
  logic [63:0] exp_res = '0;
  logic        exp_rdy = 1'b0;
  logic        busy = 1'b0;
  logic [63:0] pend = '0;
  int          left = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; exp_rdy = 1'b0; exp_res = '0;
    end else if (exp_rdy) begin
      if (annul_i || !start_i) begin
        exp_rdy = 1'b0; exp_res = '0;
      end
    end else if (busy) begin
      if (annul_i) busy = 1'b0;
      else begin
        left--;
        if (left == 0) begin
          busy = 1'b0; exp_rdy = 1'b1; exp_res = pend;
        end
      end
    end else if (start_i && !annul_i) begin
      busy = 1'b1;
      pend = golden(opdata1_i, opdata2_i, signed_div_i);
      left = (opdata2_i == 0) ? 1 : 32;
    end
  end

  always begin
    @(posedge clk);
    #1;
    check("cyc_ready", {63'd0, ready_o}, {63'd0, exp_rdy});
    check("cyc_result", result_o, exp_res);
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                     input logic [63:0] exp, input int exp_lat, input bit toggle, input int hold);
    int n;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (toggle) begin
        opdata1_i = $urandom; opdata2_i = $urandom;
      end
      if (ready_o) break;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("result", result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_result", result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", {63'd0, ready_o}, 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("quiet_ready", {63'd0, ready_o}, 64'd0);
    end
  endtask

  task automatic abort_after(input int edges, input bit use_rst);
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < edges - 1; i++) begin
      @(posedge clk); #1;
      check("abort_busy_ready", {63'd0, ready_o}, 64'd0);
    end
    @(negedge clk);
    start_i = 1'b0;
    if (use_rst) rst = 1'b1; else annul_i = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {63'd0, ready_o}, 64'd0);
    check("abort_result", result_o, 64'd0);
    rst = 1'b0; annul_i = 1'b0;
    quiet(40);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, 33, 1'b0, 5);
    run(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0, 0);
    run(32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0, 0);
    run(32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b0, 2);
    run(32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, {32'hFFFFFFFE, 32'h00000002}, 33, 1'b0, 0);
    run(32'd3, 32'd10, 1'b0, {32'h00000003, 32'h00000000}, 33, 1'b0, 0);
    run(32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 32'hFFFFFFFF}, 33, 1'b0, 0);

    abort_after(10, 1'b0);
    run(32'd9, 32'd3, 1'b0, {32'h00000000, 32'h00000003}, 33, 1'b0, 0);

    abort_after(15, 1'b1);
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 1'b0, 0);

    run(32'd1000, 32'd33, 1'b0, {32'h0000000A, 32'h0000001E}, 33, 1'b1, 5);
    run(32'hFFFFFC18, 32'd33, 1'b1, {32'hFFFFFFF6, 32'hFFFFFFE2}, 33, 1'b1, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
